imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 186 ++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - RV32I/RV64I immediate decoder feeding a small in-order output queue
// Optional feature macro: IMM_GEN_ILLEGAL_EN (flags unrecognised opcodes as format 7)
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [2:0] FMT_R     = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;

  logic [XLEN-1:0] mem_imm [DEPTH];
  logic [XLEN-1:0] mem_pc  [DEPTH];
  logic [XLEN-1:0] mem_tgt [DEPTH];
  logic [2:0]      mem_fmt [DEPTH];

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  logic push, pop;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]   dec_imm;
  logic [XLEN-1:0]   dec_tgt;
  logic [2:0]        dec_fmt;
  logic              dec_tgt_en;
  logic              dec_ill;

  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];

  // Decode the incoming instruction into a 32-bit sign-correct immediate and a format code
  always_comb begin
    imm32      = '0;
    dec_fmt    = FMT_I;
    dec_tgt_en = 1'b0;
    dec_ill    = 1'b0;
    case (opcode)
      7'b0110011: begin
        dec_fmt = FMT_R;
        imm32   = '0;
      end
      7'b0010011: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_fmt = FMT_SHAMT;
          imm32   = (XLEN == 32) ? {27'b0, in_inst[24:20]} : {26'b0, in_inst[25:20]};
        end else begin
          dec_fmt = FMT_I;
          imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
        end
      end
      7'b0000011, 7'b1100111, 7'b1110011: begin
        dec_fmt = FMT_I;
        imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      7'b1100011: begin
        dec_fmt    = FMT_B;
        dec_tgt_en = 1'b1;
        imm32      = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      end
      7'b1101111: begin
        dec_fmt    = FMT_J;
        dec_tgt_en = 1'b1;
        imm32      = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt    = FMT_U;
        dec_tgt_en = (opcode == 7'b0010111);
        imm32      = {in_inst[31:12], 12'b0};
      end
      default: begin
`ifdef IMM_GEN_ILLEGAL_EN
        dec_fmt = 3'd7;
        dec_ill = 1'b1;
        imm32   = '0;
`else
        dec_fmt = FMT_I;
        imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
`endif
      end
    endcase
    dec_imm = XLEN'(imm32);
    dec_tgt = dec_tgt_en ? (in_pc + dec_imm) : '0;
  end

  // Next-state for occupancy and pointers; flush wins over any push or pop
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  // Queue state and entry storage; reset clears everything so the head reads as zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_imm[i] <= '0;
        mem_pc[i]  <= '0;
        mem_tgt[i] <= '0;
        mem_fmt[i] <= '0;
      end
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push && !flush) begin
        mem_imm[wr_ptr_q] <= dec_imm;
        mem_pc[wr_ptr_q]  <= in_pc;
        mem_tgt[wr_ptr_q] <= dec_tgt;
        mem_fmt[wr_ptr_q] <= dec_fmt;
      end
    end
  end

`ifdef IMM_GEN_ILLEGAL_EN
  logic mem_ill [DEPTH];

  // Per-entry illegal flag, only present when illegal detection is built in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_ill[i] <= 1'b0;
    end else if (push && !flush) begin
      mem_ill[wr_ptr_q] <= dec_ill;
    end
  end

  assign out_illegal = mem_ill[rd_ptr_q];
`else
  logic unused_ill;
  assign unused_ill  = dec_ill;
  assign out_illegal = 1'b0;
`endif

  assign out_imm    = mem_imm[rd_ptr_q];
  assign out_pc     = mem_pc[rd_ptr_q];
  assign out_target = mem_tgt[rd_ptr_q];
  assign out_fmt    = mem_fmt[rd_ptr_q];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - randomized and directed checks of imm_gen_pipe against a behavioural model
module tb_imm_gen_pipe;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic [31:0] out_pc;
  logic [31:0] out_target;
  logic        out_illegal;

  logic        in_valid64 = 1'b0;
  logic        in_ready64;
  logic [31:0] in_inst64 = '0;
  logic [63:0] in_pc64 = '0;
  logic        out_valid64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;
  logic [63:0] out_pc64;
  logic [63:0] out_target64;
  logic        out_illegal64;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [63:0] pc;
    logic [63:0] tgt;
    bit          ill;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_pc(out_pc), .out_target(out_target), .out_illegal(out_illegal)
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(2)) u_dut64 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_inst(in_inst64), .in_pc(in_pc64),
    .out_valid(out_valid64), .out_ready(1'b1), .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_pc(out_pc64), .out_target(out_target64), .out_illegal(out_illegal64)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Immediate value computed from the instruction fields as plain signed arithmetic
  function automatic exp_t ref_dec(input logic [31:0] inst, input logic [63:0] pc, input int xlen);
    exp_t   e;
    longint v;
    bit     rel;
    logic [6:0] op;
    logic [2:0] f3;
    op  = inst[6:0];
    f3  = inst[14:12];
    v   = 0;
    rel = 0;
    e.ill = 0;
    case (op)
      7'h33: begin e.fmt = 0; v = 0; end
      7'h13: begin
        if (f3 == 1 || f3 == 5) begin
          e.fmt = 6;
          v = (xlen == 32) ? longint'(inst[24:20]) : longint'(inst[25:20]);
        end else begin
          e.fmt = 1;
          v = longint'(inst[30:20]) - (inst[31] ? 2048 : 0);
        end
      end
      7'h03, 7'h67, 7'h73: begin e.fmt = 1; v = longint'(inst[30:20]) - (inst[31] ? 2048 : 0); end
      7'h23: begin
        e.fmt = 2;
        v = longint'(inst[31:25]) * 32 + longint'(inst[11:7]);
        if (v >= 2048) v = v - 4096;
      end
      7'h63: begin
        e.fmt = 3; rel = 1;
        v = longint'(inst[7]) * 2048 + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2
            - (inst[31] ? 4096 : 0);
      end
      7'h6F: begin
        e.fmt = 5; rel = 1;
        v = longint'(inst[19:12]) * 4096 + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2
            - (inst[31] ? 1048576 : 0);
      end
      7'h37, 7'h17: begin
        e.fmt = 4; rel = (op == 7'h17);
        v = longint'(inst[31:12]) * 4096 - (inst[31] ? 64'h1_0000_0000 : 0);
      end
      default: begin
`ifdef IMM_GEN_ILLEGAL_EN
        e.fmt = 7; e.ill = 1; v = 0;
`else
        e.fmt = 1; v = longint'(inst[30:20]) - (inst[31] ? 2048 : 0);
`endif
      end
    endcase
    e.imm = 64'(v);
    e.pc  = pc;
    e.tgt = rel ? (pc + e.imm) : 64'd0;
    if (xlen == 32) begin
      e.imm = {32'd0, e.imm[31:0]};
      e.tgt = {32'd0, e.tgt[31:0]};
      e.pc  = {32'd0, e.pc[31:0]};
    end
    return e;
  endfunction

  task automatic check_outputs();
    chk("in_ready", in_ready, exp_q.size() < DEPTH);
    chk("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("out_imm", out_imm, exp_q[0].imm);
      chk("out_fmt", out_fmt, exp_q[0].fmt);
      chk("out_pc", out_pc, exp_q[0].pc);
      chk("out_target", out_target, exp_q[0].tgt);
      chk("out_illegal", out_illegal, exp_q[0].ill);
    end
  endtask

  // Apply inputs for the next edge, advance the model, then check after the edge
  task automatic step(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                      input bit ordy, input bit fl);
    bit do_push, do_pop;
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
    if (fl) begin
      exp_q.delete();
    end else begin
      do_push = v && (exp_q.size() < DEPTH);
      do_pop  = ordy && (exp_q.size() != 0);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(ref_dec(inst, {32'd0, pc}, 32));
    end
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic step64(input logic [31:0] inst, input logic [63:0] pc);
    exp_t e;
    e = ref_dec(inst, pc, 64);
    in_valid64 = 1'b1; in_inst64 = inst; in_pc64 = pc;
    @(posedge clk); #1;
    in_valid64 = 1'b0;
    chk("x64_valid", out_valid64, 1);
    chk("x64_imm", out_imm64, e.imm);
    chk("x64_fmt", out_fmt64, e.fmt);
    chk("x64_pc", out_pc64, e.pc);
    chk("x64_target", out_target64, e.tgt);
    @(posedge clk); #1;
    chk("x64_drained", out_valid64, 0);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [10];
    logic [31:0] r;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17};
    r = $urandom;
    if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 9)];
    return r;
  endfunction

  initial begin
    // reset state
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_target", out_target, 0);
    chk("rst_out_fmt", out_fmt, 0);
    chk("rst_out_illegal", out_illegal, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // branch backward
    step(1, 32'hFE000EE3, 32'h100, 0, 0);
    chk("b_fmt", out_fmt, 3);
    chk("b_imm", out_imm, 32'hFFFFFFFC);
    chk("b_target", out_target, 32'h000000FC);
    step(1, 32'h4030D093, 32'h0, 1, 0);
    chk("srai_fmt", out_fmt, 6);
    chk("srai_imm", out_imm, 32'h3);
    step(1, 32'h0080006F, 32'h200, 1, 0);
    chk("jal_fmt", out_fmt, 5);
    chk("jal_imm", out_imm, 32'h8);
    chk("jal_target", out_target, 32'h208);
    step(0, 32'h0, 32'h0, 1, 0);

    // unrecognised opcode
    step(1, 32'h0000007F, 32'h40, 0, 0);
`ifdef IMM_GEN_ILLEGAL_EN
    chk("ill_fmt", out_fmt, 7);
    chk("ill_flag", out_illegal, 1);
    chk("ill_imm", out_imm, 0);
`else
    chk("ill_fmt", out_fmt, 1);
    chk("ill_flag", out_illegal, 0);
`endif
    step(0, 32'h0, 32'h0, 1, 0);

    // backpressure: three pushes into two entries
    step(1, 32'h00500093, 32'h10, 0, 0);
    step(1, 32'h00A00113, 32'h14, 0, 0);
    chk("full_in_ready", in_ready, 0);
    step(1, 32'h00F00193, 32'h18, 0, 0);
    chk("held_in_ready", in_ready, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    chk("pop1_in_ready", in_ready, 1);
    chk("pop1_head_pc", out_pc, 32'h14);
    step(0, 32'h0, 32'h0, 1, 0);

    // flush while full, with push and pop requested
    step(1, 32'h00100093, 32'h20, 0, 0);
    step(1, 32'h00200093, 32'h24, 0, 0);
    step(1, 32'h00300093, 32'h28, 1, 1);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);

    // async reset mid-drain
    step(1, 32'h00400093, 32'h30, 0, 0);
    step(1, 32'h00500093, 32'h34, 1, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_imm", out_imm, 0);
    exp_q.delete();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #2 rst = 1'b0;
    step(1, 32'h00600093, 32'h38, 0, 0);
    chk("post_rst_push", out_valid, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rand_inst(), $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 31) == 0);
    end

    // 64-bit datapath
    in_valid = 1'b0; out_ready = 1'b0;
    step64(32'h80000037, 64'h0);
    chk("lui64_imm", out_imm64, 0);
    for (int i = 0; i < 40; i++) begin
      step64(rand_inst(), {$urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
